// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and shared sizing constants for the SPI transmit/receive buffers
package spi_pkg;
  typedef enum logic {IDLE, RECEIVE} spi_state_t;
  localparam int SPI_WIDTH = 8;
  localparam int SPI_N = 8;
  localparam int SPI_CNT_W = 5;
endpackage

// File: rtl/spi_rx_shift_byte.sv
// spi_rx_shift_byte: WIDTH-bit serial-in shifter with bit counter, strobes byte_done on the last bit
// Bit order is MSB first by default; defining SPI_RX_LSB_FIRST_EN shifts LSB first.
module spi_rx_shift_byte #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_done
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bit_cnt;
  // byte_out already includes the bit being sampled this edge
`ifdef SPI_RX_LSB_FIRST_EN
  assign byte_out = (sr >> 1) | (WIDTH'(din) << (WIDTH - 1));
`else
  assign byte_out = (sr << 1) | WIDTH'(din);
`endif
  assign byte_done = en && bit_cnt == BW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sr      <= byte_out;
      bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
    end
endmodule

// File: rtl/nbit_miso_spi_receive_buffer.sv
// nbit_miso_spi_receive_buffer: deserializes i_MISO into up to N WIDTH-bit bytes packed byte 0 lowest
// Optional SPI_RX_LSB_FIRST_EN selects LSB-first bit order in the shifter.
module nbit_miso_spi_receive_buffer
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int N     = SPI_N
) (
  input  logic                 i_SCK,
  input  logic                 i_RST_N,
  input  logic                 i_START,
  input  logic [SPI_CNT_W-1:0] i_N_receive,
  input  logic                 i_MISO,
  output logic [WIDTH*N-1:0]   o_DATA,
  output logic [WIDTH-1:0]     o_BYTE,
  output logic                 o_BYTE_VALID,
  output logic                 o_DONE,
  output logic                 o_BUSY,
  output logic [SPI_CNT_W-1:0] o_BYTE_IDX
);
  spi_state_t           state, state_nxt;
  logic [SPI_CNT_W-1:0] byte_idx, n_tgt;
  logic [WIDTH-1:0]     rx_byte;
  logic                 rx_done, start_ok, last;
  assign start_ok   = state == IDLE && i_START && i_N_receive != '0;
  assign last       = rx_done && byte_idx == n_tgt - 1'b1;
  assign o_BUSY     = state == RECEIVE;
  assign o_BYTE_IDX = byte_idx;
  spi_rx_shift_byte #(.WIDTH(WIDTH)) u_shift (
    .clk      (i_SCK),
    .rst_n    (i_RST_N),
    .clr      (start_ok),
    .en       (o_BUSY),
    .din      (i_MISO),
    .byte_out (rx_byte),
    .byte_done(rx_done)
  );
  always_ff @(posedge i_SCK or negedge i_RST_N)
    if (!i_RST_N) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = start_ok ? RECEIVE : last ? IDLE : state;
  // Oversized requests clamp to N so byte_idx can never address a missing slot
  always_ff @(posedge i_SCK or negedge i_RST_N)
    if (!i_RST_N) begin
      o_DATA       <= '0;
      o_BYTE       <= '0;
      o_BYTE_VALID <= 1'b0;
      o_DONE       <= 1'b0;
      byte_idx     <= '0;
      n_tgt        <= '0;
    end else begin
      o_BYTE_VALID <= rx_done;
      o_DONE       <= last;
      if (start_ok) begin
        n_tgt    <= i_N_receive > SPI_CNT_W'(N) ? SPI_CNT_W'(N) : i_N_receive;
        byte_idx <= '0;
        o_DATA   <= '0;
      end else if (rx_done) begin
        o_BYTE <= rx_byte;
        for (int i = 0; i < N; i++)
          if (byte_idx == SPI_CNT_W'(i)) o_DATA[i*WIDTH +: WIDTH] <= rx_byte;
        if (!last) byte_idx <= byte_idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_nbit_miso_spi_receive_buffer.sv
// tb_nbit_miso_spi_receive_buffer: directed self-checking bench for the MISO receive buffer
// The serializer follows SPI_RX_LSB_FIRST_EN so the same expected bytes hold in both bit orders.
module tb_nbit_miso_spi_receive_buffer;
  localparam int W = 8;
  localparam int NB = 8;
  logic          i_SCK = 1'b0;
  logic          i_RST_N = 1'b0;
  logic          i_START = 1'b0;
  logic          i_MISO = 1'b0;
  logic [4:0]    i_N_receive = '0;
  logic [W*NB-1:0] o_DATA;
  logic [W-1:0]  o_BYTE;
  logic          o_BYTE_VALID, o_DONE, o_BUSY;
  logic [4:0]    o_BYTE_IDX;
  int n_chk = 0;
  int n_fail = 0;

  nbit_miso_spi_receive_buffer #(.WIDTH(W), .N(NB)) dut (
    .i_SCK       (i_SCK),
    .i_RST_N     (i_RST_N),
    .i_START     (i_START),
    .i_N_receive (i_N_receive),
    .i_MISO      (i_MISO),
    .o_DATA      (o_DATA),
    .o_BYTE      (o_BYTE),
    .o_BYTE_VALID(o_BYTE_VALID),
    .o_DONE      (o_DONE),
    .o_BUSY      (o_BUSY),
    .o_BYTE_IDX  (o_BYTE_IDX)
  );

  always #5 i_SCK = ~i_SCK;

  task automatic tick;
    @(posedge i_SCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rx_burst(input logic [4:0] nreq, input int nexp, input logic [63:0] data, input bit hold);
    logic [63:0] exp_data;
    logic [7:0]  b;
    int          spur;
    exp_data = '0;
    i_START = 1'b1;
    i_N_receive = nreq;
    tick;
    check("start_busy", 64'(o_BUSY), 64'd1);
    check("start_clear", 64'(o_DATA), 64'd0);
    check("start_idx", 64'(o_BYTE_IDX), 64'd0);
    if (!hold) i_START = 1'b0;
    for (int j = 0; j < nexp; j++) begin
      b = data[j*8 +: 8];
      spur = 0;
      for (int i = 0; i < W; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
        i_MISO = b[i];
`else
        i_MISO = b[W-1-i];
`endif
        tick;
        if (i < W - 1 && (o_BYTE_VALID || o_DONE)) spur++;
      end
      check("no_early_pulse", 64'(spur), 64'd0);
      check("byte_valid", 64'(o_BYTE_VALID), 64'd1);
      check("byte", 64'(o_BYTE), 64'(b));
      check("done", 64'(o_DONE), 64'(j == nexp - 1));
      exp_data[j*8 +: 8] = b;
      check("data", 64'(o_DATA), exp_data);
      if (j < nexp - 1) check("idx", 64'(o_BYTE_IDX), 64'(j + 1));
    end
  endtask

  task automatic after_burst(input logic [63:0] exp_data);
    tick;
    check("idle_busy", 64'(o_BUSY), 64'd0);
    check("done_pulse", 64'(o_DONE), 64'd0);
    check("valid_pulse", 64'(o_BYTE_VALID), 64'd0);
    check("data_hold", 64'(o_DATA), exp_data);
  endtask

  initial begin
    int bad;
    tick;
    tick;
    check("rst_data", 64'(o_DATA), 64'd0);
    check("rst_busy", 64'(o_BUSY), 64'd0);
    check("rst_done", 64'(o_DONE), 64'd0);
    check("rst_valid", 64'(o_BYTE_VALID), 64'd0);
    #2 i_RST_N = 1'b1;
    tick;
    rx_burst(5'd1, 1, 64'hA5, 1'b0);
    after_burst(64'hA5);
    rx_burst(5'd3, 3, 64'h563412, 1'b0);
    after_burst(64'h563412);
    i_START = 1'b1;
    i_N_receive = 5'd0;
    tick;
    check("n0_busy", 64'(o_BUSY), 64'd0);
    tick;
    check("n0_busy2", 64'(o_BUSY), 64'd0);
    check("n0_data", 64'(o_DATA), 64'h563412);
    i_START = 1'b0;
    rx_burst(5'd20, 8, 64'h8877665544332211, 1'b0);
    after_burst(64'h8877665544332211);
    rx_burst(5'd2, 2, 64'hBBAA, 1'b1);
    rx_burst(5'd2, 2, 64'hDDCC, 1'b1);
    i_START = 1'b0;
    after_burst(64'hDDCC);
    i_START = 1'b1;
    i_N_receive = 5'd2;
    tick;
    i_START = 1'b0;
    i_MISO = 1'b1;
    for (int i = 0; i < 11; i++) tick;
    check("pre_rst_byte", 64'(o_BYTE), 64'hFF);
    i_RST_N = 1'b0;
    #1;
    check("arst_data", 64'(o_DATA), 64'd0);
    check("arst_byte", 64'(o_BYTE), 64'd0);
    check("arst_busy", 64'(o_BUSY), 64'd0);
    check("arst_idx", 64'(o_BYTE_IDX), 64'd0);
    check("arst_valid", 64'(o_BYTE_VALID), 64'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (o_DONE || o_BUSY || o_BYTE_VALID) bad++;
    end
    check("arst_quiet", 64'(bad), 64'd0);
    #2 i_RST_N = 1'b1;
    i_MISO = 1'b0;
    tick;
    rx_burst(5'd2, 2, 64'h5AC3, 1'b0);
    after_burst(64'h5AC3);
    rx_burst(5'd3, 3, 64'h3C81AF, 1'b0);
    after_burst(64'h3C81AF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nbit_miso_spi_receive_buffer.md
Name: nbit_miso_spi_receive_buffer

Overview:
- Receive-side counterpart of the MOSI transmit buffer.
- Samples serial data on i_MISO and deserializes it into WIDTH-bit bytes.
- Packs up to N bytes into one wide word, byte 0 in the low bits, which is the same ordering the transmit buffer consumes.
- Sits between the SPI pins and the controller FSM; used for status/ID reads and for a loopback self-test against the MOSI path.

Parameters:
- WIDTH, 8: bits per byte.
- N, 8: maximum bytes per burst; 1..31.

Ports:
- i_SCK, input, 1: serial clock; all logic on rising edge.
- i_RST_N, input, 1: asynchronous active-low reset.
- i_START, input, 1: request a receive burst.
- i_N_receive, input, 5: number of bytes to receive.
- i_MISO, input, 1: serial data in.
- o_DATA, output, WIDTH*N: packed received bytes; byte k at [k*WIDTH +: WIDTH].
- o_BYTE, output, WIDTH: most recently completed byte.
- o_BYTE_VALID, output, 1: one-cycle pulse when o_BYTE updates.
- o_DONE, output, 1: one-cycle pulse on the final byte of a burst.
- o_BUSY, output, 1: high while in RECEIVE.
- o_BYTE_IDX, output, 5: index of the byte currently being received.

Behaviour:
- Reset (i_RST_N low, asynchronous):
  - state=IDLE.
  - All outputs 0; bit counter, byte counter and shift register 0.
  - A reset mid-burst discards partial data; no o_DONE is produced.
- States:
  - IDLE: o_BUSY=0.
    - On an edge with i_START=1 and i_N_receive>0: latch n_tgt = min(i_N_receive, N); clear o_DATA to 0; byte_idx=0; bit_cnt=0; go to RECEIVE.
    - i_START with i_N_receive=0: ignored, stay IDLE.
  - RECEIVE: o_BUSY=1.
    - Each edge: shift i_MISO into the shift register, MSB first (the first sampled bit becomes bit WIDTH-1); bit_cnt++.
    - On the edge where bit_cnt==WIDTH-1:
      - The completed byte (shift register plus the current bit) is written to o_BYTE and to o_DATA slot byte_idx.
      - o_BYTE_VALID=1 for that cycle; bit_cnt returns to 0.
      - If byte_idx==n_tgt-1: o_DONE=1 and state goes to IDLE. Otherwise byte_idx++.
    - i_START is ignored while in RECEIVE; there is no re-latch mid-burst.
- Latency:
  - i_START is sampled at edge k.
  - The first data bit is sampled at edge k+1.
  - Byte j completes at edge k+(j+1)*WIDTH.
  - o_DONE rises at edge k+n_tgt*WIDTH.
- Back-to-back bursts: the controller may assert i_START on the cycle after o_DONE. The bit immediately after the final bit is not captured (one dead SCK cycle).
- o_DATA slots above n_tgt stay 0. o_DATA holds its value until the next accepted i_START.
- o_BYTE_VALID and o_DONE are registered single-cycle pulses. They are never held high across consecutive edges except for consecutive bytes at WIDTH=1.
- Counter widths:
  - bit_cnt: ceil(log2(WIDTH)), minimum 1.
  - byte_idx: 5 bits.
  - i_N_receive > N clamps to N, with no wrap.

Optional Feature:
- Macro SPI_RX_LSB_FIRST_EN.
  - Defined: bits shift in LSB first; the first sampled bit becomes bit 0.
  - Undefined (default): MSB first, matching the SSD1331 and the transmit path.
- Timing, counters and handshakes are identical in both modes.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding (IDLE, RECEIVE);
  - the default WIDTH/N constants shared with the transmit buffer;
  - the 5-bit count width constant.
- One sub-module, spi_rx_shift_byte: WIDTH-bit shifter plus bit counter; outputs the byte and a byte_done strobe.
- The top level owns the FSM, byte_idx and o_DATA packing.

Test Plan:
- Reset: assert i_RST_N=0 mid-burst (after 11 bits of a 2-byte burst) → all outputs 0 immediately; no o_DONE; the next burst works normally.
- Single byte: i_START, i_N_receive=1, MISO stream 1010_0101 → o_BYTE=0xA5 and o_BYTE_VALID and o_DONE together 8 edges after the start edge; o_DATA[7:0]=0xA5, upper bits 0.
- Multi-byte: i_N_receive=3 with bytes 0x12, 0x34, 0x56 → three o_BYTE_VALID pulses 8 edges apart; o_DONE with the third; o_DATA[23:0]=0x563412.
- Boundary counts:
  - i_N_receive=0 → stays IDLE, o_BUSY=0.
  - i_N_receive=20 with N=8 → exactly 8 bytes, o_DONE after 64 bits.
- Back-to-back and ignored start: i_START held high throughout two bursts of 2 bytes → the second burst starts the edge after o_DONE and its o_DATA is cleared first; i_START mid-burst has no effect.
- Loopback: MOSI buffer output tied to i_MISO, sending 0xAF,0x81,0x3C → received o_DATA[23:0]=0x3C81AF; repeat with SPI_RX_LSB_FIRST_EN defined and the transmitter bit-reversed → same result.
